// File: rtl/turn_executor_if.sv
// Bundled handshake/bus signals between path_mapping, the sequencer and the motor stage.
interface turn_executor_if;
   logic       start;
   logic       halt;
   logic [2:0] line_sense;
   logic       node_flag;
   logic [1:0] turn_flag;
   logic       node_changed;
   logic [1:0] motor_l;
   logic [1:0] motor_r;
   logic [4:0] node_count;
   logic       busy;
   logic       fault;

   // Controller side: drives commands and sensors, observes motion outputs.
   modport master (
      output start, halt, line_sense, node_flag, turn_flag,
      input  node_changed, motor_l, motor_r, node_count, busy, fault
   );

   // Sequencer side.
   modport slave (
      input  start, halt, line_sense, node_flag, turn_flag,
      output node_changed, motor_l, motor_r, node_count, busy, fault
   );
endinterface

// File: rtl/turn_executor.sv
// Line-following motion sequencer: follows the line, detects nodes, centres and turns.
module turn_executor #(
   parameter int unsigned CENTER_CYCLES   = 5_000_000,
   parameter int unsigned LOSE_MIN_CYCLES = 500_000,
   parameter int unsigned TURN_TIMEOUT    = 150_000_000
) (
   input logic           clk_50M,
   input logic           rst_n,
   turn_executor_if.slave bus
);

   localparam int unsigned CNT_W = 28;
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CENTER_LAST = CNT_W'(CENTER_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOSE_LAST   = CNT_W'(LOSE_MIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TURN_TIMEOUT - 1);

   localparam logic [1:0] MOT_FWD  = 2'b10;
   localparam logic [1:0] MOT_REV  = 2'b01;
   localparam logic [1:0] MOT_STOP = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FOLLOW,
      S_CENTER,
      S_TURN_LOSE,
      S_TURN_FIND,
      S_FAULT
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_tmo, w_tmo_nxt;
   logic [1:0]       r_turn_reg, w_turn_nxt;
   logic [1:0]       r_passes, w_passes_nxt;
   logic             r_nf, r_nf_d;
   logic [1:0]       r_motor_l, w_motor_l_nxt;
   logic [1:0]       r_motor_r, w_motor_r_nxt;
   logic             r_node_changed, w_node_changed_nxt;
   logic [4:0]       r_node_count, w_node_count_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_fault, w_fault_nxt;
   logic             w_node_edge;
   logic             w_c;

   // Saturating counter increment.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Line-following steering; all-off keeps the previous command.
   function automatic logic [3:0] follow_cmd(input logic [2:0] ls, input logic [3:0] held);
      logic [3:0] cmd;
      cmd = held;
      case (ls)
         3'b010, 3'b111, 3'b101: cmd = {MOT_FWD, MOT_FWD};
         3'b100, 3'b110:         cmd = {MOT_STOP, MOT_FWD};
         3'b001, 3'b011:         cmd = {MOT_FWD, MOT_STOP};
         default:                cmd = held;
      endcase
      return cmd;
   endfunction

   // Spin direction: left turn spins left, right and U-turn spin right.
   function automatic logic [3:0] spin_cmd(input logic [1:0] turn);
      return (turn == 2'd3) ? {MOT_REV, MOT_FWD} : {MOT_FWD, MOT_REV};
   endfunction

   assign w_node_edge = r_nf & ~r_nf_d;
   assign w_c         = bus.line_sense[1];

   // node_flag sampling and edge-detect history, active in every state.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         r_nf   <= 1'b0;
         r_nf_d <= 1'b0;
      end else begin
         r_nf   <= bus.node_flag;
         r_nf_d <= r_nf;
      end
   end

   // State register.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state, counters and next output values.
   always_comb begin
      logic [3:0] cmd;
      w_state_nxt        = r_state;
      w_cnt_nxt          = r_cnt;
      w_tmo_nxt          = r_tmo;
      w_turn_nxt         = r_turn_reg;
      w_passes_nxt       = r_passes;
      w_motor_l_nxt      = r_motor_l;
      w_motor_r_nxt      = r_motor_r;
      w_node_changed_nxt = 1'b0;
      w_node_count_nxt   = r_node_count;
      cmd                = {r_motor_l, r_motor_r};

      case (r_state)
         S_IDLE: begin
            cmd = {MOT_STOP, MOT_STOP};
            if (bus.start) begin
               w_node_changed_nxt = 1'b1;
               w_node_count_nxt   = 5'd0;
               w_state_nxt        = S_FOLLOW;
            end
         end
         S_FOLLOW: begin
            cmd = follow_cmd(bus.line_sense, {r_motor_l, r_motor_r});
            if (w_node_edge) begin
               w_node_changed_nxt = 1'b1;
               w_node_count_nxt   = r_node_count + 5'd1;
               w_cnt_nxt          = '0;
               cmd                = {MOT_FWD, MOT_FWD};
               w_state_nxt        = S_CENTER;
            end
         end
         S_CENTER: begin
            cmd       = {MOT_FWD, MOT_FWD};
            w_cnt_nxt = sat_inc(r_cnt);
            if (r_cnt >= CENTER_LAST) begin
               w_turn_nxt = bus.turn_flag;
               if (bus.turn_flag == 2'd0) begin
                  w_state_nxt = S_FOLLOW;
               end else begin
                  cmd          = spin_cmd(bus.turn_flag);
                  w_passes_nxt = (bus.turn_flag == 2'd2) ? 2'd2 : 2'd1;
                  w_cnt_nxt    = '0;
                  w_tmo_nxt    = '0;
                  w_state_nxt  = S_TURN_LOSE;
               end
            end
         end
         S_TURN_LOSE: begin
            cmd       = spin_cmd(r_turn_reg);
            w_tmo_nxt = sat_inc(r_tmo);
            if (r_tmo >= TMO_LAST) begin
               cmd         = {MOT_STOP, MOT_STOP};
               w_state_nxt = S_FAULT;
            end else if (w_c) begin
               w_cnt_nxt = '0;
            end else if (r_cnt >= LOSE_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_TURN_FIND;
            end else begin
               w_cnt_nxt = sat_inc(r_cnt);
            end
         end
         S_TURN_FIND: begin
            cmd       = spin_cmd(r_turn_reg);
            w_tmo_nxt = sat_inc(r_tmo);
            if (r_tmo >= TMO_LAST) begin
               cmd         = {MOT_STOP, MOT_STOP};
               w_state_nxt = S_FAULT;
            end else if (w_c) begin
               w_passes_nxt = r_passes - 2'd1;
               if (r_passes <= 2'd1) begin
                  w_passes_nxt = 2'd0;
                  cmd          = follow_cmd(bus.line_sense, {r_motor_l, r_motor_r});
                  w_state_nxt  = S_FOLLOW;
               end else begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_TURN_LOSE;
               end
            end
         end
         S_FAULT: begin
            cmd = {MOT_STOP, MOT_STOP};
         end
         default: begin
            cmd         = {MOT_STOP, MOT_STOP};
            w_state_nxt = S_IDLE;
         end
      endcase

      // Abort has priority over everything except a latched fault.
      if (bus.halt && (r_state != S_FAULT)) begin
         cmd                = {MOT_STOP, MOT_STOP};
         w_state_nxt        = S_IDLE;
         w_node_changed_nxt = 1'b0;
         w_node_count_nxt   = r_node_count;
         w_turn_nxt         = 2'd0;
         w_passes_nxt       = 2'd0;
         w_cnt_nxt          = '0;
         w_tmo_nxt          = '0;
      end

      w_motor_l_nxt = cmd[3:2];
      w_motor_r_nxt = cmd[1:0];
      w_busy_nxt    = (w_state_nxt != S_IDLE) && (w_state_nxt != S_FAULT);
      w_fault_nxt   = r_fault | (w_state_nxt == S_FAULT);
   end

   // Datapath and output registers.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt          <= '0;
         r_tmo          <= '0;
         r_turn_reg     <= 2'd0;
         r_passes       <= 2'd0;
         r_motor_l      <= MOT_STOP;
         r_motor_r      <= MOT_STOP;
         r_node_changed <= 1'b0;
         r_node_count   <= 5'd0;
         r_busy         <= 1'b0;
         r_fault        <= 1'b0;
      end else begin
         r_cnt          <= w_cnt_nxt;
         r_tmo          <= w_tmo_nxt;
         r_turn_reg     <= w_turn_nxt;
         r_passes       <= w_passes_nxt;
         r_motor_l      <= w_motor_l_nxt;
         r_motor_r      <= w_motor_r_nxt;
         r_node_changed <= w_node_changed_nxt;
         r_node_count   <= w_node_count_nxt;
         r_busy         <= w_busy_nxt;
         r_fault        <= w_fault_nxt;
      end
   end

   assign bus.motor_l      = r_motor_l;
   assign bus.motor_r      = r_motor_r;
   assign bus.node_changed = r_node_changed;
   assign bus.node_count   = r_node_count;
   assign bus.busy         = r_busy;
   assign bus.fault        = r_fault;

endmodule

// File: tb/tb_turn_executor.sv
// Directed bench for turn_executor with small timing parameters.
module tb_turn_executor;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   turn_executor_if bus();

   turn_executor #(
      .CENTER_CYCLES  (10),
      .LOSE_MIN_CYCLES(4),
      .TURN_TIMEOUT   (200)
   ) dut (
      .clk_50M(clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] ls;
      logic [3:0] mot;
   } vec_t;

   vec_t vecs[9];

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_mot(input string name, input logic [3:0] exp);
      check(name, 32'({bus.motor_l, bus.motor_r}), 32'(exp));
   endtask

   // Raise node_flag, confirm the node_changed pulse and count, then ride out CENTER.
   task automatic arrive(input logic [1:0] tf, input logic [4:0] exp_cnt, input string tag);
      bus.turn_flag = tf;
      bus.node_flag = 1'b1;
      step(1);
      check({tag, "_no_early_pulse"}, 32'(bus.node_changed), 32'd0);
      step(1);
      check({tag, "_node_changed"}, 32'(bus.node_changed), 32'd1);
      check({tag, "_node_count"}, 32'(bus.node_count), 32'(exp_cnt));
      bus.node_flag = 1'b0;
      step(9);
      check_mot({tag, "_center_fwd"}, 4'b1010);
      check({tag, "_single_pulse"}, 32'(bus.node_changed), 32'd0);
      step(1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.start      = 1'b0;
      bus.halt       = 1'b0;
      bus.line_sense = 3'b010;
      bus.node_flag  = 1'b0;
      bus.turn_flag  = 2'd0;

      vecs[0] = '{3'b010, 4'b1010};
      vecs[1] = '{3'b100, 4'b0010};
      vecs[2] = '{3'b000, 4'b0010};
      vecs[3] = '{3'b001, 4'b1000};
      vecs[4] = '{3'b011, 4'b1000};
      vecs[5] = '{3'b000, 4'b1000};
      vecs[6] = '{3'b110, 4'b0010};
      vecs[7] = '{3'b111, 4'b1010};
      vecs[8] = '{3'b101, 4'b1010};

      // Reset values
      step(2);
      check_mot("reset_motors", 4'b0000);
      check("reset_node_changed", 32'(bus.node_changed), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_fault", 32'(bus.fault), 32'd0);
      rst_n = 1'b1;
      step(1);

      // Start
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      check("start_pulse", 32'(bus.node_changed), 32'd1);
      check("start_busy", 32'(bus.busy), 32'd1);
      check("start_count", 32'(bus.node_count), 32'd0);
      step(1);
      check("start_pulse_end", 32'(bus.node_changed), 32'd0);

      // Follow steering table
      for (int i = 0; i < 9; i++) begin
         bus.line_sense = vecs[i].ls;
         step(1);
         check_mot($sformatf("follow_vec%0d", i), vecs[i].mot);
      end

      // Right turn
      bus.line_sense = 3'b010;
      step(1);
      arrive(2'd1, 5'd1, "right");
      check_mot("right_spin", 4'b1001);
      bus.line_sense = 3'b000;
      step(4);
      check_mot("right_lose_spin", 4'b1001);
      check("right_busy", 32'(bus.busy), 32'd1);
      bus.line_sense = 3'b010;
      step(1);
      check_mot("right_done_fwd", 4'b1010);
      bus.line_sense = 3'b100;
      step(1);
      check_mot("right_back_follow", 4'b0010);

      // U-turn with a glitch during the first lose phase
      bus.line_sense = 3'b010;
      step(1);
      arrive(2'd2, 5'd2, "uturn");
      check_mot("uturn_spin", 4'b1001);
      bus.line_sense = 3'b000; step(2);
      bus.line_sense = 3'b010; step(1);
      bus.line_sense = 3'b000; step(3);
      bus.line_sense = 3'b010; step(1);
      check_mot("uturn_glitch_spin", 4'b1001);
      bus.line_sense = 3'b000; step(4);
      bus.line_sense = 3'b010; step(1);
      check_mot("uturn_pass1_spin", 4'b1001);
      bus.line_sense = 3'b000; step(4);
      bus.line_sense = 3'b010; step(1);
      check_mot("uturn_done_fwd", 4'b1010);
      bus.line_sense = 3'b001; step(1);
      check_mot("uturn_back_follow", 4'b1000);

      // Straight with node_flag held high through CENTER
      bus.line_sense = 3'b010;
      step(1);
      bus.turn_flag = 2'd0;
      bus.node_flag = 1'b1;
      step(2);
      check("straight_pulse", 32'(bus.node_changed), 32'd1);
      check("straight_count", 32'(bus.node_count), 32'd3);
      begin
         int pulses;
         pulses = 0;
         for (int i = 0; i < 15; i++) begin
            step(1);
            if (bus.node_changed) pulses++;
         end
         check("straight_no_retrigger", 32'(pulses), 32'd0);
      end
      check("straight_count_held", 32'(bus.node_count), 32'd3);
      bus.line_sense = 3'b110;
      step(1);
      check_mot("straight_follow", 4'b0010);
      bus.line_sense = 3'b010;
      bus.node_flag  = 1'b0;
      step(1);
      bus.node_flag = 1'b1;
      step(2);
      check("straight_new_edge", 32'(bus.node_count), 32'd4);
      bus.node_flag = 1'b0;
      step(12);

      // halt and start together during TURN_LOSE
      arrive(2'd1, 5'd5, "halt");
      bus.line_sense = 3'b000;
      step(1);
      bus.halt  = 1'b1;
      bus.start = 1'b1;
      step(1);
      bus.halt  = 1'b0;
      bus.start = 1'b0;
      check_mot("halt_motors", 4'b0000);
      check("halt_busy", 32'(bus.busy), 32'd0);
      check("halt_count_kept", 32'(bus.node_count), 32'd5);
      check("halt_no_pulse", 32'(bus.node_changed), 32'd0);
      step(1);
      check("halt_stays_idle", 32'(bus.busy), 32'd0);

      // Asynchronous reset mid-turn
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      bus.line_sense = 3'b010;
      step(1);
      arrive(2'd3, 5'd1, "rst");
      check_mot("rst_spin_left", 4'b0110);
      rst_n = 1'b0;
      #1;
      check_mot("rst_async_motors", 4'b0000);
      check("rst_async_busy", 32'(bus.busy), 32'd0);
      check("rst_async_count", 32'(bus.node_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1);

      // Turn timeout into FAULT
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      bus.line_sense = 3'b010;
      step(1);
      arrive(2'd3, 5'd1, "tmo");
      bus.line_sense = 3'b000;
      step(195);
      check("tmo_not_yet", 32'(bus.fault), 32'd0);
      check("tmo_busy_before", 32'(bus.busy), 32'd1);
      step(10);
      check("tmo_fault", 32'(bus.fault), 32'd1);
      check("tmo_busy", 32'(bus.busy), 32'd0);
      check_mot("tmo_motors", 4'b0000);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      step(1);
      check("fault_ignores_start", 32'({bus.busy, bus.fault, bus.node_changed}), 32'b010);
      bus.halt = 1'b1;
      step(1);
      bus.halt = 1'b0;
      step(1);
      check("fault_ignores_halt", 32'({bus.busy, bus.fault}), 32'b01);
      rst_n = 1'b0;
      #1;
      check("fault_cleared_by_reset", 32'(bus.fault), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
